// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C slave address decoder.
//   state_t         : address-decode FSM states
//   ADDR10_PREFIX   : upper five bits of a 10-bit address first byte
//   GEN_CALL_ADDR   : general-call first byte
//   RSVD_PREFIX_*   : 7-bit address groups reserved by the bus protocol
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR10_LO,
    ST_SELECTED,
    ST_UNSELECTED
  } state_t;

  localparam logic [4:0] ADDR10_PREFIX  = 5'b11110;
  localparam logic [7:0] GEN_CALL_ADDR  = 8'h00;
  localparam logic [3:0] RSVD_PREFIX_LO = 4'b0000;
  localparam logic [3:0] RSVD_PREFIX_HI = 4'b1111;

endpackage

// File: rtl/i2c_addr_cmp.sv
// Combinational masked address compare.
//   a   : received address bits
//   b   : own address bits
//   m   : mask, 1 = bit ignored
//   hit : 1 when every unmasked bit of a equals b
module i2c_addr_cmp #(
  parameter int W = 7
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] m,
  output logic         hit
);

  assign hit = (((a ^ b) & ~m) == '0);

endmodule

// File: rtl/i2c_addr_match.sv
// I2C slave address decoder: 7-bit or 10-bit address match with mask and
// general call, tracking the 10-bit write / repeated-START read sequence.
//   SCL          : bus clock, all logic on its rising edge
//   Reset_n      : synchronous active-low reset
//   ShiftRegOut  : received byte, bit 0 = R/W
//   LoadDeviceId : strobe, ShiftRegOut holds a complete byte
//   StartDet     : strobe, START or repeated START
//   StopDet      : strobe, STOP
//   WR           : R/W bit of the selecting address (1 = read)
//   Match        : slave selected for the current transfer
//   GenCall      : selected through general call
//   AddrAck      : one-cycle request to ACK the byte just loaded
//
// state         | meaning
// --------------+--------------------------------------------------
// ST_IDLE       | bus free or after STOP, bytes ignored
// ST_ADDR       | after START, next byte is an address byte
// ST_ADDR10_LO  | 10-bit high byte matched, waiting for low byte
// ST_SELECTED   | addressed, data bytes not decoded
// ST_UNSELECTED | not addressed, wait for START/STOP
module i2c_addr_match
  import i2c_pkg::*;
#(
  parameter int          ADDR_MODE   = 0,
  parameter logic [9:0]  DEVICE_ADDR = 10'h018,
  parameter logic [9:0]  ADDR_MASK   = 10'h000,
  parameter int          GEN_CALL_EN = 1
) (
  input  logic       SCL,
  input  logic       Reset_n,
  input  logic [7:0] ShiftRegOut,
  input  logic       LoadDeviceId,
  input  logic       StartDet,
  input  logic       StopDet,
  output logic       WR,
  output logic       Match,
  output logic       GenCall,
  output logic       AddrAck
);

  localparam bit MODE10 = (ADDR_MODE != 0);
  localparam bit GC_EN  = (GEN_CALL_EN != 0);

  state_t state_q, state_d;
  logic   wr_q, wr_d;
  logic   match_q, match_d;
  logic   gen_call_q, gen_call_d;
  logic   addr_ack_q, addr_ack_d;
  logic   held10_q, held10_d;

  logic hit7, hit_hi, hit_lo;
  logic is_gen_call, is_rsvd, is_hi10;

  i2c_addr_cmp #(.W(7)) u_cmp7 (
    .a   (ShiftRegOut[7:1]),
    .b   (DEVICE_ADDR[6:0]),
    .m   (ADDR_MASK[6:0]),
    .hit (hit7)
  );

  i2c_addr_cmp #(.W(2)) u_cmp_hi (
    .a   (ShiftRegOut[2:1]),
    .b   (DEVICE_ADDR[9:8]),
    .m   (ADDR_MASK[9:8]),
    .hit (hit_hi)
  );

  i2c_addr_cmp #(.W(8)) u_cmp_lo (
    .a   (ShiftRegOut),
    .b   (DEVICE_ADDR[7:0]),
    .m   (ADDR_MASK[7:0]),
    .hit (hit_lo)
  );

  assign is_gen_call = GC_EN && (ShiftRegOut == GEN_CALL_ADDR);
  assign is_rsvd     = (ShiftRegOut[7:4] == RSVD_PREFIX_LO) ||
                       (ShiftRegOut[7:4] == RSVD_PREFIX_HI);
  assign is_hi10     = (ShiftRegOut[7:3] == ADDR10_PREFIX) && hit_hi;

  always_comb begin
    state_d    = state_q;
    wr_d       = wr_q;
    match_d    = match_q;
    gen_call_d = gen_call_q;
    held10_d   = held10_q;
    addr_ack_d = 1'b0;

    if (StopDet) begin
      // STOP together with START behaves as STOP followed by START.
      state_d    = StartDet ? ST_ADDR : ST_IDLE;
      match_d    = 1'b0;
      gen_call_d = 1'b0;
      held10_d   = 1'b0;
    end else if (StartDet) begin
      // Held10 survives a repeated START so the 10-bit read can select.
      state_d    = ST_ADDR;
      match_d    = 1'b0;
      gen_call_d = 1'b0;
    end else if (LoadDeviceId) begin
      case (state_q)
        ST_ADDR: begin
          if (is_gen_call) begin
            state_d    = ST_SELECTED;
            match_d    = 1'b1;
            gen_call_d = 1'b1;
            wr_d       = 1'b0;
            addr_ack_d = 1'b1;
          end else if (!MODE10) begin
            if (!is_rsvd && hit7) begin
              state_d    = ST_SELECTED;
              match_d    = 1'b1;
              wr_d       = ShiftRegOut[0];
              addr_ack_d = 1'b1;
            end else begin
              state_d = ST_UNSELECTED;
            end
          end else if (is_hi10) begin
            if (!ShiftRegOut[0]) begin
              state_d    = ST_ADDR10_LO;
              addr_ack_d = 1'b1;
            end else if (held10_q) begin
              state_d    = ST_SELECTED;
              match_d    = 1'b1;
              wr_d       = 1'b1;
              addr_ack_d = 1'b1;
            end else begin
              state_d = ST_UNSELECTED;
            end
          end else begin
            state_d  = ST_UNSELECTED;
            held10_d = 1'b0;
          end
        end
        ST_ADDR10_LO: begin
          if (hit_lo) begin
            state_d    = ST_SELECTED;
            match_d    = 1'b1;
            wr_d       = 1'b0;
            held10_d   = 1'b1;
            addr_ack_d = 1'b1;
          end else begin
            state_d  = ST_UNSELECTED;
            held10_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge SCL) begin
    if (!Reset_n) begin
      state_q    <= ST_IDLE;
      wr_q       <= 1'b0;
      match_q    <= 1'b0;
      gen_call_q <= 1'b0;
      addr_ack_q <= 1'b0;
      held10_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_d;
      match_q    <= match_d;
      gen_call_q <= gen_call_d;
      addr_ack_q <= addr_ack_d;
      held10_q   <= held10_d;
    end
  end

  assign WR      = wr_q;
  assign Match   = match_q;
  assign GenCall = gen_call_q;
  assign AddrAck = addr_ack_q;

endmodule
